// File: rtl/mux0_uart_pkg.sv
// Shared CPU6 I/O definitions for the MUX0 serial port: base address,
// status bit positions and the TX/RX state encodings.
package mux0_uart_pkg;

    localparam logic [18:0] MUX0_BASE_ADDR = 19'h3f200;

    localparam int ST_RXRDY  = 0;
    localparam int ST_TXRDY  = 1;
    localparam int ST_FE     = 2;
    localparam int ST_OVR    = 3;
    localparam int ST_TXBUSY = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO for the TX path. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate flag. DEPTH >= 2.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same edge, so a push on a full FIFO is kept then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mux0_uart.sv
// MUX channel 0 serial port on the CPU6 bus: status/data registers, TX FIFO
// feeding an 8N1 transmitter, and an 8N1 receiver with a one-byte holding register.
module mux0_uart
    import mux0_uart_pkg::*;
#(
    parameter logic [18:0] BASE_ADDR    = MUX0_BASE_ADDR,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [18:0] address,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        selected,
    output logic        txd,
    input  logic        rxd
);

    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam int          FW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [18:0] DATA_ADDR = BASE_ADDR + 19'd1;

    logic sel_status, sel_data, data_wr, data_rd;

    assign sel_status = (address == BASE_ADDR);
    assign sel_data   = (address == DATA_ADDR);
    assign selected   = sel_status || sel_data;
    assign data_wr    = write_en && sel_data;
    assign data_rd    = read_en && sel_data;

    logic          fifo_full, fifo_empty, tx_load;
    logic [7:0]    fifo_rd_data;
    logic [FW:0]   fifo_count;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (data_wr),
        .pop     (tx_load),
        .wr_data (data_in),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift;
    logic          tx_shift_en, txd_n;

    // txd is registered and loaded one bit ahead so each cell starts on its edge.
    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt;
        tx_bit_n    = tx_bit;
        txd_n       = txd;
        tx_load     = 1'b0;
        tx_shift_en = 1'b0;
        if (tx_state == TX_IDLE) begin
            if (!fifo_empty) begin
                tx_load    = 1'b1;
                tx_state_n = TX_START;
                tx_cnt_n   = '0;
                txd_n      = 1'b0;
            end
        end else begin
            tx_cnt_n = tx_cnt + 1'b1;
            if (tx_cnt == BIT_END) begin
                tx_cnt_n = '0;
                case (tx_state)
                    TX_START: begin
                        tx_state_n = TX_DATA;
                        tx_bit_n   = '0;
                        txd_n      = tx_shift[0];
                    end
                    TX_DATA: begin
                        if (tx_bit == 3'd7) begin
                            tx_state_n = TX_STOP;
                            txd_n      = 1'b1;
                        end else begin
                            tx_bit_n    = tx_bit + 1'b1;
                            tx_shift_en = 1'b1;
                            txd_n       = tx_shift[1];
                        end
                    end
                    TX_STOP: begin
                        if (!fifo_empty) begin
                            tx_load    = 1'b1;
                            tx_state_n = TX_START;
                            txd_n      = 1'b0;
                        end else begin
                            tx_state_n = TX_IDLE;
                        end
                    end
                    default: tx_state_n = TX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            txd      <= txd_n;
        end
    end

    always_ff @(posedge clock) begin
        if (tx_load)          tx_shift <= fifo_rd_data;
        else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};
    end

    logic          rx_s1, rx_s2, rx_s3;
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_hold;
    logic          rx_sample, rx_done_ok;
    logic          rxrdy, fe, ovr, rxrdy_n, fe_n, ovr_n;

    // rx_s2 is the synchronised line; rx_s3 only exists to detect its falling edge.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_sample  = 1'b0;
        rx_done_ok = 1'b0;
        rxrdy_n    = data_rd ? 1'b0 : rxrdy;
        fe_n       = data_rd ? 1'b0 : fe;
        ovr_n      = data_rd ? 1'b0 : ovr;
        case (rx_state)
            RX_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == HALF_END) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n  = '0;
                    rx_sample = 1'b1;
                    rx_bit_n  = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_s2) begin
                        // A same-edge read consumed the old byte, so no overrun then.
                        rx_done_ok = 1'b1;
                        ovr_n      = ovr_n | (rxrdy & ~data_rd);
                        rxrdy_n    = 1'b1;
                    end else begin
                        fe_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_hold  <= 8'h00;
            rxrdy    <= 1'b0;
            fe       <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rxrdy    <= rxrdy_n;
            fe       <= fe_n;
            ovr      <= ovr_n;
            if (rx_done_ok) rx_hold <= rx_shift;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_sample) rx_shift <= {rx_s2, rx_shift[7:1]};
    end

    logic [7:0] status;

    always_comb begin
        status            = '0;
        status[ST_RXRDY]  = rxrdy;
        status[ST_TXRDY]  = !fifo_full;
        status[ST_FE]     = fe;
        status[ST_OVR]    = ovr;
        status[ST_TXBUSY] = (fifo_count != '0) || (tx_state != TX_IDLE);
    end

    always_comb begin
        data_out = '0;
        if (sel_status)    data_out = status;
        else if (sel_data) data_out = rx_hold;
    end

endmodule

// File: tb/tb_mux0_uart.sv
// Bench for mux0_uart: register-map vector table, a TX frame decoder feeding a
// byte scoreboard, and hand-written RX, FIFO and reset sequences.
module tb_mux0_uart;

    localparam int          CPB  = 16;
    localparam logic [18:0] ST_A = 19'h3f200;
    localparam logic [18:0] DT_A = 19'h3f201;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [18:0] address = '0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        selected;
    logic        txd;
    logic        rxd = 1'b1;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    bit          mon_en = 1'b0;

    typedef struct {
        bit          we;
        logic [18:0] waddr;
        logic [7:0]  din;
        logic [18:0] raddr;
        logic        exp_sel;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[8];

    mux0_uart #(.BASE_ADDR(19'h3f200), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .address  (address),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .data_out (data_out),
        .selected (selected),
        .txd      (txd),
        .rxd      (rxd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [7:0] exp);
        address = ST_A;
        #1;
        check(name, 32'(data_out), 32'(exp));
    endtask

    task automatic check_data(input string name, input logic [7:0] exp);
        address = DT_A;
        #1;
        check(name, 32'(data_out), 32'(exp));
    endtask

    task automatic clear_read();
        address = DT_A;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) tick();
        end
        rxd = stop;
        repeat (CPB) tick();
        rxd = 1'b1;
        repeat (2*CPB) tick();
    endtask

    // TX frame decoder: samples each cell near its centre and scores the byte.
    initial begin : tx_mon
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b    = '0;
        forever begin
            tick();
            if (mon_en && prev && !txd) begin
                start_q.push_back(cyc);
                repeat (CPB/2 - 1) tick();
                check("tx_start_bit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) tick();
                    b[i] = txd;
                end
                repeat (CPB) tick();
                check("tx_stop_bit", 32'(txd), 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", b);
                end else begin
                    check("tx_byte", 32'(b), 32'(exp_q.pop_front()));
                end
                prev = 1'b1;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin : main
        logic [9:0] fr;
        int         errs;
        int         t;

        vecs[0] = '{1'b0, 19'h0,     8'h00, 19'h3f200, 1'b1, 8'h02};
        vecs[1] = '{1'b0, 19'h0,     8'h00, 19'h3f201, 1'b1, 8'h00};
        vecs[2] = '{1'b0, 19'h0,     8'h00, 19'h3f1ff, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 19'h0,     8'h00, 19'h3f202, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 19'h0,     8'h00, 19'h00000, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 19'h0,     8'h00, 19'h7f200, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 19'h0,     8'h00, 19'h3f000, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 19'h3f200, 8'hff, 19'h3f200, 1'b1, 8'h02};

        reset_n = 1'b0;
        repeat (3) tick();
        check("reset_txd", 32'(txd), 32'd1);
        check_status("reset_status", 8'h02);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].din);
            address = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d_selected", i), 32'(selected), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].exp_dout));
        end
        repeat (CPB) tick();
        check("status_write_no_tx", 32'(txd), 32'd1);

        // Single byte 0x48
        mon_en = 1'b1;
        exp_q.push_back(8'h48);
        bus_write(DT_A, 8'h48);
        check("tx_before_pop", 32'(txd), 32'd1);
        address = ST_A;
        fr = {1'b1, 8'h48, 1'b0};
        for (int c = 0; c < 10; c++) begin
            errs = 0;
            for (int k = 0; k < CPB; k++) begin
                tick();
                if (txd !== fr[c]) errs++;
            end
            check($sformatf("single_cell%0d_bad_clocks", c), 32'(errs), 32'd0);
        end
        check("txbusy_at_stop_end", 32'(data_out[4]), 32'd1);
        tick();
        check("txbusy_cleared", 32'(data_out), 32'h02);
        repeat (20) tick();
        check("single_queue_drained", 32'(exp_q.size()), 32'd0);

        // FIFO fill: six back-to-back writes, sixth dropped
        start_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h41 + i));
        address  = DT_A;
        write_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 8'(8'h41 + i);
            tick();
            if (i == 4) begin
                address = ST_A;
                #1;
                check("fifo_full_txrdy", 32'(data_out[1]), 32'd0);
                address = DT_A;
            end
        end
        write_en = 1'b0;
        check_status("txrdy_after_drop", 8'h10);
        t = 0;
        while (exp_q.size() != 0 && t < 6*10*CPB) begin
            tick();
            t++;
        end
        check("fifo_frames_timeout", 32'(exp_q.size()), 32'd0);
        repeat (12*CPB) tick();
        check("fifo_frame_count", 32'(start_q.size()), 32'd5);
        for (int i = 1; i < 5 && i < start_q.size(); i++)
            check($sformatf("fifo_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(10*CPB));
        check_status("fifo_idle_status", 8'h02);

        // RX good byte
        send_rx(8'h55, 1'b1);
        check_status("rx55_status", 8'h03);
        check_data("rx55_data", 8'h55);
        clear_read();
        check_status("rx55_cleared", 8'h02);

        // RX glitch shorter than half a bit
        rxd = 1'b0;
        repeat (3) tick();
        rxd = 1'b1;
        repeat (2*CPB) tick();
        check_status("rx_glitch_ignored", 8'h02);

        // RX framing error
        send_rx(8'ha5, 1'b0);
        check_status("rx_fe_status", 8'h06);
        clear_read();
        check_status("rx_fe_cleared", 8'h02);

        // RX overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check_status("rx_ovr_status", 8'h0b);
        check_data("rx_ovr_data", 8'h22);
        clear_read();
        check_status("rx_ovr_cleared", 8'h02);

        // Reset during bit 3 of a TX frame with bytes queued
        mon_en = 1'b0;
        bus_write(DT_A, 8'hf0);
        bus_write(DT_A, 8'h33);
        bus_write(DT_A, 8'h44);
        repeat (68) tick();
        check("mid_frame_bit3_low", 32'(txd), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_txd", 32'(txd), 32'd1);
        repeat (2) tick();
        reset_n = 1'b1;
        check_status("post_reset_status", 8'h02);
        errs = 0;
        repeat (20*CPB) begin
            tick();
            if (txd !== 1'b1) errs++;
        end
        check("no_residual_tx", 32'(errs), 32'd0);
        check_status("post_reset_idle_status", 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
